// File: rtl/uart_rsp_pkg.sv
// uart_rsp_pkg: constants and types shared by the UART register responder.
//   - Command opcodes and response codes exchanged with the host.
//   - FSM state encoding of the responder.
package uart_rsp_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W' addr data
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R' addr
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_RESP     = 3'd3,
    ST_TX_ACK   = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_e;

endpackage

// File: rtl/uart_rsp_sync.sv
// uart_rsp_sync: two-flop synchroniser for a level crossing into clk_i.
//   RISE_EDGE = 1 : q_o is a one-cycle pulse on each rising edge of the
//                   synchronised level.
//   RISE_EDGE = 0 : q_o is the synchronised level itself.
// Ports:
//   clk_i  in  1  destination clock
//   rst_ni in  1  asynchronous active-low reset
//   d_i    in  1  asynchronous input level
//   q_o    out 1  synchronised level or rising-edge pulse
module uart_rsp_sync #(
  parameter bit RISE_EDGE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Two-stage metastability filter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  if (RISE_EDGE) begin : g_rise
    logic prev_q;

    // Delayed copy of the synchronised level for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= sync_q[1];
      end
    end

    assign q_o = sync_q[1] & ~prev_q;
  end else begin : g_level
    assign q_o = sync_q[1];
  end

endmodule

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: serial command responder giving a host read/write
// access to a bank of 8-bit registers through the Uart8 rx/tx user side.
//   Write: 'W'(57) addr data -> ACK(06).   Read: 'R'(52) addr -> reg[addr].
//   Unknown opcode, out-of-range addr or errored byte -> NAK(15).
// Ports:
//   clk, rstN                 clock, asynchronous active-low reset
//   rxDone, rxErr, rxData     receiver handshake (rxDone/rxErr are resynchronised)
//   txBusy                    transmitter busy (resynchronised)
//   rxEn, txEn                receiver / transmitter enables, high after reset
//   txStart, txData           transmit request and byte
//   regOut                    flattened register bank, reg k at [8k+7:8k]
//   wrStrobe, wrAddr          one-cycle pulse and address of each write
// Optional build macro UART_RSP_TIMEOUT_EN: a partial command is discarded
// after TIMEOUT_CYCLES of inter-byte silence.
module uart_reg_responder
  import uart_rsp_pkg::*;
#(
  parameter int          NUM_REGS       = 16,
  parameter int          TIMEOUT_CYCLES = 100000000,
  parameter logic [7:0]  RESET_VALUE    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  rxDone,
  input  logic                  rxErr,
  input  logic [7:0]            rxData,
  input  logic                  txBusy,
  output logic                  rxEn,
  output logic                  txEn,
  output logic                  txStart,
  output logic [7:0]            txData,
  output logic [8*NUM_REGS-1:0] regOut,
  output logic                  wrStrobe,
  output logic [7:0]            wrAddr
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
    $error("uart_reg_responder: NUM_REGS must be in 1..256");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_reg_responder: TIMEOUT_CYCLES must be at least 1");
  end

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    rsp_q, rsp_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic          en_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic          reg_we_s;

  logic          rx_rise_s, rx_err_s, tx_busy_s;
  logic          addr_ok_s;
  logic [AW-1:0] rx_idx_s;
  logic          tmo_hit_s;

  uart_rsp_sync #(.RISE_EDGE(1'b1)) u_sync_rx_done (
    .clk_i(clk), .rst_ni(rstN), .d_i(rxDone), .q_o(rx_rise_s)
  );
  uart_rsp_sync #(.RISE_EDGE(1'b0)) u_sync_rx_err (
    .clk_i(clk), .rst_ni(rstN), .d_i(rxErr), .q_o(rx_err_s)
  );
  uart_rsp_sync #(.RISE_EDGE(1'b0)) u_sync_tx_busy (
    .clk_i(clk), .rst_ni(rstN), .d_i(txBusy), .q_o(tx_busy_s)
  );

  // 9-bit compare so NUM_REGS = 256 accepts every byte value.
  assign addr_ok_s = ({1'b0, rxData} < 9'(NUM_REGS));
  assign rx_idx_s  = rxData[AW-1:0];

`ifdef UART_RSP_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit_s = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Silence counter: counts only while a command is partially received.
  always_comb begin
    tmo_d = {TW{1'b0}};
    if ((state_q == ST_GET_ADDR || state_q == ST_GET_DATA) && !rx_rise_s && !tmo_hit_s) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = {TW{1'b0}};
    end
  end

  // Silence counter register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tmo_q <= {TW{1'b0}};
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Command FSM next-state and datapath decisions.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    rsp_d       = rsp_q;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    reg_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_rise_s) begin
          if (!rx_err_s && rxData == OP_WRITE) begin
            is_wr_d = 1'b1;
            state_d = ST_GET_ADDR;
          end else if (!rx_err_s && rxData == OP_READ) begin
            is_wr_d = 1'b0;
            state_d = ST_GET_ADDR;
          end else begin
            rsp_d   = RSP_NAK;
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_ADDR: begin
        if (rx_rise_s) begin
          if (rx_err_s || !addr_ok_s) begin
            rsp_d   = RSP_NAK;
            state_d = ST_RESP;
          end else if (is_wr_q) begin
            addr_d  = rx_idx_s;
            state_d = ST_GET_DATA;
          end else begin
            // Snapshot now so the response reflects the value at addr time.
            rsp_d   = regs_q[rx_idx_s];
            state_d = ST_RESP;
          end
        end else if (tmo_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GET_ADDR;
        end
      end
      ST_GET_DATA: begin
        if (rx_rise_s) begin
          if (rx_err_s) begin
            rsp_d = RSP_NAK;
          end else begin
            reg_we_s    = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = 8'(addr_q);
            rsp_d       = RSP_ACK;
          end
          state_d = ST_RESP;
        end else if (tmo_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GET_DATA;
        end
      end
      ST_RESP: begin
        tx_data_d  = rsp_q;
        tx_start_d = 1'b1;
        state_d    = ST_TX_ACK;
      end
      ST_TX_ACK: begin
        if (tx_busy_s) begin
          tx_start_d = 1'b0;
          state_d    = ST_TX_WAIT;
        end else begin
          state_d = ST_TX_ACK;
        end
      end
      ST_TX_WAIT: begin
        if (!tx_busy_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TX_WAIT;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      addr_q      <= {AW{1'b0}};
      rsp_q       <= 8'h00;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      rsp_q       <= rsp_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      en_q        <= 1'b1;
    end
  end

  // Register bank; written from the data byte in GET_DATA.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VALUE;
      end
    end else if (reg_we_s) begin
      regs_q[addr_q] <= rxData;
    end else begin
      regs_q <= regs_q;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign regOut[8*k +: 8] = regs_q[k];
  end

  assign rxEn     = en_q;
  assign txEn     = en_q;
  assign txStart  = tx_start_q;
  assign txData   = tx_data_q;
  assign wrStrobe = wr_strobe_q;
  assign wrAddr   = wr_addr_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: drives host bytes on the rx
// side, emulates the transmitter handshake and checks responses and the
// register bank against a reference array of register contents.
module tb_uart_reg_responder;

  localparam int NR = 16;
`ifdef UART_RSP_TIMEOUT_EN
  localparam int TMO = 1000;
`else
  localparam int TMO = 100000000;
`endif

  logic            clk = 1'b0;
  logic            rstN;
  logic            rxDone, rxErr, txBusy;
  logic [7:0]      rxData;
  logic            rxEn, txEn, txStart, wrStrobe;
  logic [7:0]      txData, wrAddr;
  logic [8*NR-1:0] regOut;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] ref_regs [NR];
  logic [7:0] tx_q [$];
  bit         tx_active = 1'b0;
  int         wr_cnt = 0;
  logic [7:0] last_wr_addr = 8'h00;

  always #5 clk = ~clk;

  uart_reg_responder #(.NUM_REGS(NR), .TIMEOUT_CYCLES(TMO), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxData(rxData),
    .txBusy(txBusy), .rxEn(rxEn), .txEn(txEn), .txStart(txStart), .txData(txData),
    .regOut(regOut), .wrStrobe(wrStrobe), .wrAddr(wrAddr)
  );

  function automatic logic [8*NR-1:0] ref_flat();
    logic [8*NR-1:0] f;
    for (int k = 0; k < NR; k++) f[8*k +: 8] = ref_regs[k];
    return f;
  endfunction

  // Transmitter emulation: captures each frame and checks the handshake.
  initial begin : tx_model
    logic [7:0] cap;
    int dly;
    txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (rstN === 1'b1 && txStart === 1'b1) begin
        cap = txData;
        tx_q.push_back(cap);
        tx_active = 1'b1;
        dly = $urandom_range(1, 3);
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          checks++;
          if (txStart !== 1'b1) begin
            failures++;
            $display("FAIL tx_start_hold got=%b exp=1", txStart);
          end
        end
        txBusy = 1'b1;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          checks++;
          if (txData !== cap) begin
            failures++;
            $display("FAIL tx_data_stable got=%h exp=%h", txData, cap);
          end
        end
        checks++;
        if (txStart !== 1'b0) begin
          failures++;
          $display("FAIL tx_start_release got=%b exp=0", txStart);
        end
        txBusy = 1'b0;
        repeat (4) @(negedge clk);
        tx_active = 1'b0;
      end
    end
  end

  // Write strobe monitor.
  initial begin : wr_mon
    forever begin
      @(negedge clk);
      if (wrStrobe === 1'b1) begin
        wr_cnt++;
        last_wr_addr = wrAddr;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input bit err);
    @(negedge clk);
    rxData = d;
    rxErr  = err;
    rxDone = 1'b1;
    repeat (4) @(negedge clk);
    rxDone = 1'b0;
    rxErr  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic get_tx(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    b  = 8'h00;
    while ((tx_q.size() == 0 || tx_active) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx_q.size() != 0 && !tx_active) begin
      b  = tx_q.pop_front();
      ok = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstN = 1'b1; rxDone = 1'b0; rxErr = 1'b0; rxData = 8'h00;
    #2 rstN = 1'b0;
    for (int k = 0; k < NR; k++) ref_regs[k] = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (regOut !== ref_flat()) begin failures++; $display("FAIL reset_regs got=%h exp=%h", regOut, ref_flat()); end
    checks++;
    if ({txStart, txData, wrStrobe, wrAddr} !== 18'h0) begin
      failures++; $display("FAIL reset_outputs got=%b/%h/%b/%h exp=0", txStart, txData, wrStrobe, wrAddr);
    end
    checks++;
    if ({rxEn, txEn} !== 2'b00) begin failures++; $display("FAIL reset_enables got=%b exp=00", {rxEn, txEn}); end
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if ({rxEn, txEn} !== 2'b11) begin failures++; $display("FAIL enables_after_reset got=%b exp=11", {rxEn, txEn}); end
  endtask

  task automatic test_write();
    logic [7:0] b; bit ok; int w0;
    w0 = wr_cnt;
    send_byte(8'h57, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'hA5, 1'b0);
    ref_regs[3] = 8'hA5;
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'h06) begin failures++; $display("FAIL write_ack got=%h ok=%0d exp=06", b, ok); end
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_addr !== 8'h03) begin
      failures++; $display("FAIL write_strobe got=%0d@%h exp=1@03", wr_cnt - w0, last_wr_addr);
    end
    checks++;
    if (regOut !== ref_flat()) begin failures++; $display("FAIL write_regs got=%h exp=%h", regOut, ref_flat()); end
  endtask

  task automatic test_read();
    logic [7:0] b; bit ok;
    send_byte(8'h52, 1'b0); send_byte(8'h03, 1'b0);
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'hA5) begin failures++; $display("FAIL read_back got=%h ok=%0d exp=a5", b, ok); end
  endtask

  task automatic test_bad_addr();
    logic [7:0] b; bit ok;
    send_byte(8'h52, 1'b0); send_byte(8'h10, 1'b0);
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'h15) begin failures++; $display("FAIL bad_addr_nak got=%h ok=%0d exp=15", b, ok); end
    checks++;
    if (regOut !== ref_flat()) begin failures++; $display("FAIL bad_addr_regs got=%h exp=%h", regOut, ref_flat()); end
    send_byte(8'h41, 1'b0);
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'h15) begin failures++; $display("FAIL bad_op_nak got=%h ok=%0d exp=15", b, ok); end
  endtask

  task automatic test_rx_err();
    logic [7:0] b; bit ok;
    send_byte(8'h57, 1'b0); send_byte(8'h01, 1'b1);
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'h15) begin failures++; $display("FAIL rx_err_nak got=%h ok=%0d exp=15", b, ok); end
    send_byte(8'h52, 1'b0); send_byte(8'h00, 1'b0);
    get_tx(b, ok);
    checks++;
    if (!ok || b !== ref_regs[0]) begin failures++; $display("FAIL after_err_read got=%h ok=%0d exp=%h", b, ok, ref_regs[0]); end
  endtask

  task automatic test_drop();
    logic [7:0] b; bit ok; int n;
    send_byte(8'h57, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h3C, 1'b0);
    ref_regs[1] = 8'h3C;
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'h06) begin failures++; $display("FAIL drop_setup_ack got=%h ok=%0d exp=06", b, ok); end
    send_byte(8'h52, 1'b0); send_byte(8'h01, 1'b0);
    n = 0;
    while (txBusy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (txBusy !== 1'b1) begin failures++; $display("FAIL drop_busy_wait got=%b exp=1", txBusy); end
    send_byte(8'h41, 1'b0);  // would draw a NAK if it were not dropped
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'h3C) begin failures++; $display("FAIL drop_read got=%h ok=%0d exp=3c", b, ok); end
    repeat (40) @(negedge clk);
    checks++;
    if (tx_q.size() != 0) begin failures++; $display("FAIL drop_extra_frames got=%0d exp=0", tx_q.size()); end
    send_byte(8'h52, 1'b0); send_byte(8'h01, 1'b0);
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'h3C) begin failures++; $display("FAIL drop_followup got=%h ok=%0d exp=3c", b, ok); end
  endtask

  task automatic test_random();
    logic [7:0] b, a, d, op, exp; bit ok; int kind, w0, wexp;
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 4);
      w0 = wr_cnt;
      wexp = 0;
      case (kind)
        0: begin
          a = 8'($urandom_range(0, NR - 1)); d = 8'($urandom);
          send_byte(8'h57, 1'b0); send_byte(a, 1'b0); send_byte(d, 1'b0);
          ref_regs[a] = d; exp = 8'h06; wexp = 1;
        end
        1: begin
          a = 8'($urandom_range(0, NR - 1));
          send_byte(8'h52, 1'b0); send_byte(a, 1'b0);
          exp = ref_regs[a];
        end
        2: begin
          a = 8'($urandom_range(NR, 255));
          send_byte(8'h57, 1'b0); send_byte(a, 1'b0);
          exp = 8'h15;
        end
        3: begin
          a = 8'($urandom_range(NR, 255));
          send_byte(8'h52, 1'b0); send_byte(a, 1'b0);
          exp = 8'h15;
        end
        default: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
          send_byte(op, 1'b0);
          exp = 8'h15;
        end
      endcase
      get_tx(b, ok);
      checks++;
      if (!ok || b !== exp) begin failures++; $display("FAIL rand_rsp it=%0d kind=%0d got=%h ok=%0d exp=%h", it, kind, b, ok, exp); end
      checks++;
      if (regOut !== ref_flat() || wr_cnt - w0 !== wexp) begin
        failures++; $display("FAIL rand_state it=%0d regs=%h exp=%h writes=%0d exp=%0d", it, regOut, ref_flat(), wr_cnt - w0, wexp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b; bit ok;
    send_byte(8'h57, 1'b0); send_byte(8'h02, 1'b0);
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    for (int k = 0; k < NR; k++) ref_regs[k] = 8'h00;
    #1;
    checks++;
    if (regOut !== ref_flat() || txStart !== 1'b0) begin
      failures++; $display("FAIL reset_mid got=%h/%b exp=%h/0", regOut, txStart, ref_flat());
    end
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h52, 1'b0); send_byte(8'h02, 1'b0);
    get_tx(b, ok);
    checks++;
    if (!ok || b !== 8'h00) begin failures++; $display("FAIL reset_mid_read got=%h ok=%0d exp=00", b, ok); end
  endtask

`ifdef UART_RSP_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] b; bit ok;
    send_byte(8'h57, 1'b0); send_byte(8'h05, 1'b0);
    repeat (1000) @(negedge clk);
    send_byte(8'h52, 1'b0); send_byte(8'h05, 1'b0);
    get_tx(b, ok);
    checks++;
    if (!ok || b !== ref_regs[5]) begin failures++; $display("FAIL timeout_read got=%h ok=%0d exp=%h", b, ok, ref_regs[5]); end
    repeat (40) @(negedge clk);
    checks++;
    if (tx_q.size() != 0) begin failures++; $display("FAIL timeout_extra_frames got=%0d exp=0", tx_q.size()); end
  endtask
`endif

  initial begin : main
    test_reset();
    test_write();
    test_read();
    test_bad_addr();
    test_rx_err();
    test_drop();
    test_random();
    test_reset_mid();
`ifdef UART_RSP_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
